stream_checksum_appender: RTL and testbench

- Stage directly downstream of stream_data_manipulator. Consumes its valid/ready byte-enabled stream and forwards every beat through a one-deep output register.
- Optionally appends one trailer beat per packet. The trailer carries the byte-masked word sum of that packet's beats.
- Feeds the egress interface. Also exposes a completed-packet counter for status.

---
 rtl/stream_checksum_appender.sv | 149 ++++++++++++++
 tb/tb_stream_checksum_appender.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_checksum_appender.sv
// rtl/stream_checksum_appender.sv - pass-through stream stage that optionally appends a per-packet byte-masked word-sum trailer
module stream_checksum_appender #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_BUS_WIDTH-1:0]   in_data,
    input  logic [DATA_BUS_WIDTH/8-1:0] in_byte_en,
    input  logic                        in_valid,
    input  logic                        in_end,
    output logic                        in_ready,
    output logic [DATA_BUS_WIDTH-1:0]   out_data,
    output logic [DATA_BUS_WIDTH/8-1:0] out_byte_en,
    output logic                        out_valid,
    output logic                        out_end,
    input  logic                        out_ready,
    input  logic                        append_enable,
    output logic [COUNT_WIDTH-1:0]      packet_count
);

    localparam int BYTES = DATA_BUS_WIDTH / 8;

    typedef enum logic [0:0] {
        PASS    = 1'b0,
        TRAILER = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      first_beat;
    logic                      en_latched;
    logic                      eff_en;
    logic                      can_load;
    logic                      accept;
    logic                      load_beat;
    logic                      load_trailer;
    logic [DATA_BUS_WIDTH-1:0] acc;
    logic [DATA_BUS_WIDTH-1:0] masked;

    // The output register frees up either when empty or when its beat leaves this cycle.
    assign can_load = !out_valid || out_ready;

    // Input is held off while reset is asserted, during the trailer, and while egress is stalled.
    assign in_ready = !reset && (state == PASS) && can_load;
    assign accept   = in_valid && in_ready;

    // On the first beat of a packet the live enable is used; afterwards the latched copy rules.
    assign eff_en = first_beat ? append_enable : en_latched;

    // Zero the bytes whose enables are clear before they enter the sum.
    always_comb begin
        masked = '0;
        for (int i = 0; i < BYTES; i++) begin
            masked[i*8 +: 8] = in_byte_en[i] ? in_data[i*8 +: 8] : 8'h00;
        end
    end

    // Next-state and register-load decisions.
    always_comb begin
        state_next   = state;
        load_beat    = 1'b0;
        load_trailer = 1'b0;
        case (state)
            PASS: begin
                if (accept) begin
                    load_beat = 1'b1;
                    if (in_end && eff_en) begin
                        state_next = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (can_load) begin
                    load_trailer = 1'b1;
                    state_next   = PASS;
                end
            end
            default: begin
                state_next = PASS;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    // Running sum, first-beat tracking and per-packet enable latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            first_beat <= 1'b1;
            en_latched <= 1'b0;
        end else if (load_beat) begin
            if (first_beat) begin
                en_latched <= append_enable;
            end
            // A bypassed packet ends here, so its sum is dropped; otherwise the end
            // beat is still folded in before the trailer is emitted.
            if (in_end && !eff_en) begin
                acc <= '0;
            end else begin
                acc <= acc + masked;
            end
            first_beat <= in_end && !eff_en;
        end else if (load_trailer) begin
            acc        <= '0;
            first_beat <= 1'b1;
        end
    end

    // One-deep egress register: forwarded beat, trailer beat, or drain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_end     <= 1'b0;
            out_data    <= '0;
            out_byte_en <= '0;
        end else if (load_beat) begin
            out_valid   <= 1'b1;
            out_data    <= in_data;
            out_byte_en <= in_byte_en;
            out_end     <= in_end && !eff_en;
        end else if (load_trailer) begin
            out_valid   <= 1'b1;
            out_data    <= acc;
            out_byte_en <= '1;
            out_end     <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count packets whose final beat has been taken downstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            packet_count <= '0;
        end else if (out_valid && out_ready && out_end) begin
            packet_count <= packet_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_stream_checksum_appender.sv
// tb/tb_stream_checksum_appender.sv - directed table-driven bench for stream_checksum_appender
module tb_stream_checksum_appender;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_byte_en;
    logic        in_valid;
    logic        in_end;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_byte_en;
    logic        out_valid;
    logic        out_end;
    logic        out_ready;
    logic        append_enable;
    logic [15:0] packet_count;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic        valid;
        logic        last;
        logic        en;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic        exp_end;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    stream_checksum_appender #(
        .DATA_BUS_WIDTH(32),
        .COUNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_byte_en(in_byte_en),
        .in_valid(in_valid),
        .in_end(in_end),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_byte_en(out_byte_en),
        .out_valid(out_valid),
        .out_end(out_end),
        .out_ready(out_ready),
        .append_enable(append_enable),
        .packet_count(packet_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] be, input logic v,
                         input logic l, input logic en, input logic ordy);
        @(negedge clock);
        in_data       = d;
        in_byte_en    = be;
        in_valid      = v;
        in_end        = l;
        append_enable = en;
        out_ready     = ordy;
        #1;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [31:0] d,
                             input logic [3:0] be, input logic e, input logic [15:0] pc);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        if (ov) begin
            check({tag, ".out_data"}, out_data, d);
            check({tag, ".out_byte_en"}, {28'd0, out_byte_en}, {28'd0, be});
            check({tag, ".out_end"}, {31'd0, out_end}, {31'd0, e});
        end
        check({tag, ".packet_count"}, {16'd0, packet_count}, {16'd0, pc});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        in_data       = '0;
        in_byte_en    = '0;
        in_valid      = 1'b0;
        in_end        = 1'b0;
        out_ready     = 1'b0;
        append_enable = 1'b0;

        // data, be, valid, last, en, ordy | in_ready | out_valid, out_data, out_be, out_end, count
        // basic two-beat packet with trailer
        vecs.push_back('{32'h00000001, 4'hF, 1, 0, 1, 1, 1, 1, 32'h00000001, 4'hF, 0, 16'd0});
        vecs.push_back('{32'h00000002, 4'hF, 1, 1, 1, 1, 1, 1, 32'h00000002, 4'hF, 0, 16'd0});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 0, 1, 32'h00000003, 4'hF, 1, 16'd0});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 1, 0, 32'h00000000, 4'h0, 0, 16'd1});
        // single-beat packet with byte masking
        vecs.push_back('{32'hAABBCCDD, 4'h3, 1, 1, 1, 1, 1, 1, 32'hAABBCCDD, 4'h3, 0, 16'd1});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 0, 1, 32'h0000CCDD, 4'hF, 1, 16'd1});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 1, 0, 32'h00000000, 4'h0, 0, 16'd2});
        // sum wraps; follow-on packet is back-to-back with the trailer
        vecs.push_back('{32'hFFFFFFFF, 4'hF, 1, 0, 1, 1, 1, 1, 32'hFFFFFFFF, 4'hF, 0, 16'd2});
        vecs.push_back('{32'h00000002, 4'hF, 1, 1, 1, 1, 1, 1, 32'h00000002, 4'hF, 0, 16'd2});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 0, 1, 32'h00000001, 4'hF, 1, 16'd2});
        vecs.push_back('{32'h00000005, 4'hF, 1, 1, 1, 1, 1, 1, 32'h00000005, 4'hF, 0, 16'd3});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 0, 1, 32'h00000005, 4'hF, 1, 16'd3});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 1, 0, 32'h00000000, 4'h0, 0, 16'd4});
        // bypass: enable low on first beat, raised mid-packet
        vecs.push_back('{32'h00000011, 4'hF, 1, 0, 0, 1, 1, 1, 32'h00000011, 4'hF, 0, 16'd4});
        vecs.push_back('{32'h00000022, 4'hF, 1, 0, 1, 1, 1, 1, 32'h00000022, 4'hF, 0, 16'd4});
        vecs.push_back('{32'h00000033, 4'hF, 1, 1, 1, 1, 1, 1, 32'h00000033, 4'hF, 1, 16'd4});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 1, 0, 32'h00000000, 4'h0, 0, 16'd5});
        // next packet with enable high gets a trailer
        vecs.push_back('{32'h00000044, 4'hF, 1, 1, 1, 1, 1, 1, 32'h00000044, 4'hF, 0, 16'd5});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 0, 1, 32'h00000044, 4'hF, 1, 16'd5});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 1, 0, 32'h00000000, 4'h0, 0, 16'd6});
        // zero-enable beat is forwarded but adds nothing
        vecs.push_back('{32'h00000099, 4'h0, 1, 0, 1, 1, 1, 1, 32'h00000099, 4'h0, 0, 16'd6});
        vecs.push_back('{32'h00000007, 4'hF, 1, 1, 1, 1, 1, 1, 32'h00000007, 4'hF, 0, 16'd6});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 0, 1, 32'h00000007, 4'hF, 1, 16'd6});
        vecs.push_back('{32'h00000000, 4'h0, 0, 0, 1, 1, 1, 0, 32'h00000000, 4'h0, 0, 16'd7});

        // reset state
        #2;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_end", {31'd0, out_end}, 32'd0);
        check("rst.out_data", out_data, 32'd0);
        check("rst.out_byte_en", {28'd0, out_byte_en}, 32'd0);
        check("rst.packet_count", {16'd0, packet_count}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].data, vecs[i].be, vecs[i].valid, vecs[i].last, vecs[i].en, vecs[i].ordy);
            check($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
            @(posedge clock);
            #1;
            check_out($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_data,
                      vecs[i].exp_be, vecs[i].exp_end, vecs[i].exp_pc);
        end

        // backpressure: end beat stalled, then trailer stalled
        drive(32'h00000020, 4'hF, 1, 1, 1, 1);
        @(posedge clock); #1;
        check_out("bp.end", 1, 32'h00000020, 4'hF, 0, 16'd7);
        for (int k = 0; k < 4; k++) begin
            drive(32'h0, 4'h0, 0, 0, 1, 0);
            check($sformatf("bp.a%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            @(posedge clock); #1;
            check_out($sformatf("bp.a%0d", k), 1, 32'h00000020, 4'hF, 0, 16'd7);
        end
        drive(32'h0, 4'h0, 0, 0, 1, 1);
        check("bp.tr.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        check_out("bp.tr", 1, 32'h00000020, 4'hF, 1, 16'd7);
        for (int k = 0; k < 4; k++) begin
            drive(32'h0, 4'h0, 0, 0, 1, 0);
            check($sformatf("bp.b%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            @(posedge clock); #1;
            check_out($sformatf("bp.b%0d", k), 1, 32'h00000020, 4'hF, 1, 16'd7);
        end
        drive(32'h0, 4'h0, 0, 0, 1, 1);
        @(posedge clock); #1;
        check_out("bp.rel", 0, 32'h0, 4'h0, 0, 16'd8);
        drive(32'h0, 4'h0, 0, 0, 1, 1);
        check("bp.after.in_ready", {31'd0, in_ready}, 32'd1);

        // reset while a trailer is pending
        drive(32'h00000030, 4'hF, 1, 1, 1, 1);
        @(posedge clock); #1;
        check_out("mr.end", 1, 32'h00000030, 4'hF, 0, 16'd8);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("mr.out_valid", {31'd0, out_valid}, 32'd0);
        check("mr.packet_count", {16'd0, packet_count}, 32'd0);
        check("mr.in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(32'h00000010, 4'hF, 1, 1, 1, 1);
        check("mr.p.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        check_out("mr.p", 1, 32'h00000010, 4'hF, 0, 16'd0);
        drive(32'h0, 4'h0, 0, 0, 1, 1);
        @(posedge clock); #1;
        check_out("mr.tr", 1, 32'h00000010, 4'hF, 1, 16'd0);
        drive(32'h0, 4'h0, 0, 0, 1, 1);
        @(posedge clock); #1;
        check_out("mr.done", 0, 32'h0, 4'h0, 0, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
